// File: rtl/macro_bist_ctrl.sv
// Memory/macro BIST controller: LFSR stimulus, latency-matched MISR response compaction.
// Optional abort input is enabled by defining MACRO_BIST_ABORT_EN.
module macro_bist_ctrl #(
    parameter int NUM_VECTORS = 256,
    parameter int RESP_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  seed,
    input  logic [15:0] golden,
`ifdef MACRO_BIST_ABORT_EN
    input  logic        abort,
`endif
    input  logic [7:0]  resp_in,
    output logic [7:0]  stim_out,
    output logic        stim_valid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);

    localparam logic [15:0] LAST_VEC   = 16'(NUM_VECTORS - 1);
    localparam logic [15:0] LAST_DRAIN = 16'(RESP_LAT - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [15:0] sig_q, sig_d;
    logic        start_acc;
    logic        abort_hit;
    logic        pipe_clr;
    logic        dly_valid;
    logic [15:0] misr_next;
    logic [7:0]  lfsr_next;

`ifdef MACRO_BIST_ABORT_EN
    assign abort_hit = abort && (state_q == StRun || state_q == StDrain);
`else
    assign abort_hit = 1'b0;
`endif

    assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign misr_next = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000)
                       ^ {8'h00, resp_in};

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        lfsr_d    = lfsr_q;
        sig_d     = sig_q;
        start_acc = 1'b0;
        if (dly_valid) begin
            sig_d = misr_next;
        end
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = StRun;
                    lfsr_d    = (seed == 8'h00) ? 8'h01 : seed;
                    count_d   = '0;
                    sig_d     = 16'hFFFF;
                end
            end
            StRun: begin
                lfsr_d = lfsr_next;
                if (count_q == LAST_VEC) begin
                    count_d = '0;
                    state_d = (RESP_LAT > 0) ? StDrain : StDone;
                end else begin
                    count_d = count_q + 16'd1;
                end
            end
            StDrain: begin
                if (count_q == LAST_DRAIN) begin
                    count_d = '0;
                    state_d = StDone;
                end else begin
                    count_d = count_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        // Aborting freezes the signature; in-flight responses are discarded.
        if (abort_hit) begin
            state_d = StIdle;
            count_d = '0;
            sig_d   = sig_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= '0;
            lfsr_q  <= 8'h01;
            sig_q   <= 16'hFFFF;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lfsr_q  <= lfsr_d;
            sig_q   <= sig_d;
        end
    end

    assign pipe_clr = start_acc | abort_hit;

    // Valid pipe aligns MISR updates with the macro's response latency.
    generate
        if (RESP_LAT == 0) begin : g_no_pipe
            assign dly_valid = stim_valid;
        end else begin : g_pipe
            logic [RESP_LAT-1:0] pipe_q;
            always_ff @(posedge clk) begin
                if (rst || pipe_clr) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q[0] <= stim_valid;
                    for (int i = 1; i < RESP_LAT; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end
            assign dly_valid = pipe_q[RESP_LAT-1];
        end
    endgenerate

    assign stim_valid = (state_q == StRun);
    assign stim_out   = stim_valid ? lfsr_q : 8'h00;
    assign busy       = (state_q == StRun) || (state_q == StDrain);
    assign done       = (state_q == StDone);
    assign pass       = done && (sig_q == golden);
    assign signature  = sig_q;

endmodule

// File: tb/tb_macro_bist_ctrl.sv
// Directed bench for macro_bist_ctrl; four instances with different vector counts and latencies
// share one set of inputs, and each test observes the instance it targets.
module tb_macro_bist_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  seed;
    logic [15:0] golden;
    logic        abort;
    logic [7:0]  resp_in;

    logic [7:0]  so_a, so_b, so_c, so_d;
    logic        sv_a, sv_b, sv_c, sv_d;
    logic        busy_a, busy_b, busy_c, busy_d;
    logic        done_a, done_b, done_c, done_d;
    logic        pass_a, pass_b, pass_c, pass_d;
    logic [15:0] sig_a, sig_b, sig_c, sig_d;

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MACRO_BIST_ABORT_EN
`define ABORT_CONN .abort(abort),
`else
`define ABORT_CONN
`endif

    macro_bist_ctrl #(.NUM_VECTORS(4), .RESP_LAT(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .golden(golden), `ABORT_CONN
        .resp_in(resp_in), .stim_out(so_a), .stim_valid(sv_a), .busy(busy_a),
        .done(done_a), .pass(pass_a), .signature(sig_a)
    );
    macro_bist_ctrl #(.NUM_VECTORS(1), .RESP_LAT(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .golden(golden), `ABORT_CONN
        .resp_in(resp_in), .stim_out(so_b), .stim_valid(sv_b), .busy(busy_b),
        .done(done_b), .pass(pass_b), .signature(sig_b)
    );
    macro_bist_ctrl #(.NUM_VECTORS(8), .RESP_LAT(3)) u_dut_c (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .golden(golden), `ABORT_CONN
        .resp_in(resp_in), .stim_out(so_c), .stim_valid(sv_c), .busy(busy_c),
        .done(done_c), .pass(pass_c), .signature(sig_c)
    );
    macro_bist_ctrl #(.NUM_VECTORS(16), .RESP_LAT(2)) u_dut_d (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .golden(golden), `ABORT_CONN
        .resp_in(resp_in), .stim_out(so_d), .stim_valid(sv_d), .busy(busy_d),
        .done(done_d), .pass(pass_d), .signature(sig_d)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Signature after n updates with a constant response byte.
    function automatic logic [15:0] misr_ref(input int n, input logic [7:0] r);
        logic [15:0] s;
        s = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {8'h00, r};
        end
        return s;
    endfunction

    logic [7:0] exp_stim [4];

    initial begin
        exp_stim[0] = 8'h01; exp_stim[1] = 8'h02; exp_stim[2] = 8'h04; exp_stim[3] = 8'h08;
        rst = 1'b1; start = 1'b0; seed = 8'h00; golden = 16'h0000; abort = 1'b0;
        resp_in = 8'h00;
        tick(); tick();
        check_eq("rst_sig", 32'(sig_a), 32'hFFFF);
        check_eq("rst_busy", 32'(busy_a), 32'h0);
        check_eq("rst_done", 32'(done_a), 32'h0);
        check_eq("rst_valid", 32'(sv_a), 32'h0);
        check_eq("rst_stim", 32'(so_a), 32'h0);
        rst = 1'b0;
        tick();

        // Four-vector run: LFSR walk from seed 01, then drain and done.
        seed = 8'h01; resp_in = 8'h5A; golden = misr_ref(4, 8'h5A);
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("a_stim%0d", i), 32'(so_a), 32'(exp_stim[i]));
            check_eq($sformatf("a_valid%0d", i), 32'(sv_a), 32'h1);
            tick();
        end
        check_eq("a_drain_valid", 32'(sv_a), 32'h0);
        check_eq("a_drain_stim", 32'(so_a), 32'h0);
        check_eq("a_drain_busy", 32'(busy_a), 32'h1);
        tick();
        check_eq("a_done", 32'(done_a), 32'h1);
        check_eq("a_sig", 32'(sig_a), 32'(misr_ref(4, 8'h5A)));
        check_eq("a_pass", 32'(pass_a), 32'h1);
        repeat (20) tick();

        // Single vector, zero latency: signature EFDF one edge after start.
        resp_in = 8'h00; golden = 16'hEFDF;
        pulse_start();
        check_eq("b_busy", 32'(busy_b), 32'h1);
        check_eq("b_pass_early", 32'(pass_b), 32'h0);
        tick();
        check_eq("b_done", 32'(done_b), 32'h1);
        check_eq("b_sig", 32'(sig_b), 32'hEFDF);
        check_eq("b_pass", 32'(pass_b), 32'h1);
        golden = 16'h0000;
        #1;
        check_eq("b_pass_gold0", 32'(pass_b), 32'h0);
        golden = 16'hEFDF;
        tick();
        check_eq("b_hold_sig", 32'(sig_b), 32'hEFDF);
        check_eq("b_hold_pass", 32'(pass_b), 32'h1);
        repeat (20) tick();

        // 8 vectors, latency 3, zero seed; a start in mid-run must be ignored.
        seed = 8'h00; resp_in = 8'h33; golden = misr_ref(8, 8'h33);
        pulse_start();
        check_eq("a_seed0_stim", 32'(so_a), 32'h01);
        check_eq("c_seed0_stim", 32'(so_c), 32'h01);
        for (int k = 0; k <= 10; k++) begin
            check_eq($sformatf("c_busy%0d", k), 32'(busy_c), 32'h1);
            check_eq($sformatf("c_ndone%0d", k), 32'(done_c), 32'h0);
            start = (k == 3);
            tick();
        end
        start = 1'b0;
        check_eq("c_done", 32'(done_c), 32'h1);
        check_eq("c_busy_end", 32'(busy_c), 32'h0);
        check_eq("c_sig", 32'(sig_c), 32'(misr_ref(8, 8'h33)));
        check_eq("c_pass", 32'(pass_c), 32'h1);
        repeat (25) tick();

        // Reset mid-run at vector 5 of 16, then a full clean run.
        seed = 8'h01; resp_in = 8'hA5; golden = misr_ref(16, 8'hA5);
        pulse_start();
        repeat (4) tick();
        check_eq("d_vec5_valid", 32'(sv_d), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("d_rst_busy", 32'(busy_d), 32'h0);
        check_eq("d_rst_done", 32'(done_d), 32'h0);
        check_eq("d_rst_pass", 32'(pass_d), 32'h0);
        check_eq("d_rst_valid", 32'(sv_d), 32'h0);
        check_eq("d_rst_stim", 32'(so_d), 32'h0);
        check_eq("d_rst_sig", 32'(sig_d), 32'hFFFF);
        tick();
        pulse_start();
        repeat (17) tick();
        check_eq("d_ndone17", 32'(done_d), 32'h0);
        tick();
        check_eq("d_done", 32'(done_d), 32'h1);
        check_eq("d_sig", 32'(sig_d), 32'(misr_ref(16, 8'hA5)));
        check_eq("d_pass", 32'(pass_d), 32'h1);

`ifdef MACRO_BIST_ABORT_EN
        repeat (25) tick();
        // Abort in drain: 5 updates have landed, signature frozen there.
        resp_in = 8'h33; golden = misr_ref(8, 8'h33);
        pulse_start();
        repeat (8) tick();
        check_eq("c_in_drain", 32'(busy_c & ~sv_c), 32'h1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("c_abort_busy", 32'(busy_c), 32'h0);
        check_eq("c_abort_done", 32'(done_c), 32'h0);
        check_eq("c_abort_pass", 32'(pass_c), 32'h0);
        check_eq("c_abort_sig", 32'(sig_c), 32'(misr_ref(5, 8'h33)));
        tick();
        pulse_start();
        repeat (10) tick();
        check_eq("c_rerun_ndone", 32'(done_c), 32'h0);
        tick();
        check_eq("c_rerun_done", 32'(done_c), 32'h1);
        check_eq("c_rerun_sig", 32'(sig_c), 32'(misr_ref(8, 8'h33)));
        check_eq("c_rerun_pass", 32'(pass_c), 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/macro_bist_ctrl.md
MACRO_BIST_CTRL -- requirements
Module: macro_bist_ctrl

Interface
REQ-001 SHALL have parameter NUM_VECTORS, default 256, range 1..65535: stimulus vectors issued per run.
REQ-002 SHALL have parameter RESP_LAT, default 1, range 0..7: cycles from a stimulus vector to its macro response.
REQ-003 SHALL use one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  run request, sampled each cycle.
REQ-007 seed  input  8  LFSR seed, captured on accepted start.
REQ-008 golden  input  16  expected signature, compared in DONE.
REQ-009 stim_out  output  8  stimulus vector to macro under test.
REQ-010 stim_valid  output  1  stim_out carries a vector this cycle.
REQ-011 resp_in  input  8  response byte from macro under test.
REQ-012 busy  output  1  high in RUN and DRAIN.
REQ-013 done  output  1  high in DONE.
REQ-014 pass  output  1  done and signature==golden.
REQ-015 signature  output  16  current MISR contents.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE or DONE with start=1 SHALL go to RUN: lfsr<=seed (8'h00 replaced by 8'h01), vector count<=0, MISR<=16'hFFFF, latency pipe cleared.
REQ-018 start while in RUN or DRAIN SHALL be ignored.
REQ-019 In RUN, stim_valid=1 and stim_out=lfsr on every cycle; lfsr advances each RUN cycle as lfsr<={lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
REQ-020 RUN SHALL last exactly NUM_VECTORS cycles, then go to DRAIN if RESP_LAT>0, else to DONE.
REQ-021 DRAIN SHALL last exactly RESP_LAT cycles, then go to DONE.
REQ-022 Outside RUN, stim_valid=0 and stim_out=8'h00.
REQ-023 stim_valid SHALL be delayed through a RESP_LAT-deep pipe; with RESP_LAT=0 the pipe is a wire.
REQ-024 On each edge where the delayed valid is 1, MISR SHALL update: sig<={sig[14:0],1'b0} ^ (sig[15]?16'h1021:16'h0000) ^ {8'h00,resp_in}.
REQ-025 Exactly NUM_VECTORS MISR updates SHALL occur per run; the last one on the edge entering DONE.
REQ-026 With start accepted at edge N, DONE SHALL be entered at edge N+NUM_VECTORS+RESP_LAT.
REQ-027 DONE SHALL hold done, pass and signature stable until start or rst; golden changes in DONE SHALL update pass combinationally.
REQ-028 pass SHALL be 0 whenever done is 0.

Reset
REQ-029 rst SHALL, in any state including mid-run, force IDLE, lfsr=8'h01, count=0, MISR=16'hFFFF, pipe cleared.
REQ-030 Outputs during/after reset: stim_out=8'h00, stim_valid=0, busy=0, done=0, pass=0, signature=16'hFFFF.
REQ-031 rst SHALL take priority over start and abort in the same cycle.

Configuration
REQ-032 Macro MACRO_BIST_ABORT_EN defined SHALL add input abort (1 bit); abort=1 in RUN or DRAIN returns to IDLE next edge, stim_valid=0, MISR retains its value, done stays 0.
REQ-033 abort=1 in IDLE or DONE SHALL have no effect; abort and start together in RUN SHALL abort.
REQ-034 Without MACRO_BIST_ABORT_EN, no abort port SHALL exist and a run always completes.

Verification
REQ-035 NUM_VECTORS=4, seed=8'h01, start pulse -> stim_out 01,02,04,08 on consecutive cycles with stim_valid=1, then stim_valid=0.
REQ-036 NUM_VECTORS=1, RESP_LAT=0, resp_in=0, golden=16'hEFDF -> signature=16'hEFDF, done=1, pass=1 one edge after start; golden=16'h0000 -> pass=0.
REQ-037 NUM_VECTORS=8, RESP_LAT=3, start at edge N -> busy high edges N..N+10, done rises at edge N+11, exactly 8 MISR updates.
REQ-038 seed=8'h00 -> first stim_out=8'h01; start asserted during RUN -> no restart, run length unchanged.
REQ-039 rst pulsed at vector 5 of NUM_VECTORS=16 -> next cycle IDLE, all outputs at reset values; new start runs full 16 vectors.
REQ-040 With MACRO_BIST_ABORT_EN, abort in DRAIN -> IDLE next edge, done=0, pass=0, busy=0; subsequent start completes normally.
